// File: rtl/pc_sequencer.sv
// Multicycle PC/EPC sequencer: fetch, decode, control transfer and
// exception entry, driving the next-PC source select and write strobes.
module pc_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [25:0] instr_index,
    input  logic        zero,
    input  logic [31:0] alu_result,
    input  logic [31:0] alu_out,
    input  logic [31:0] mem_data,
    input  logic        instr_done,
    input  logic        exc_req,
    input  logic [1:0]  exc_code,
    output logic [31:0] pc,
    output logic [31:0] epc,
    output logic [2:0]  pc_source,
    output logic        pc_write,
    output logic        epc_write,
    output logic        ir_write,
    output logic        mem_read,
    output logic        iord,
    output logic [31:0] vec_addr,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_RESET      = 3'd0,
        S_FETCH      = 3'd1,
        S_FETCH_WAIT = 3'd2,
        S_DECODE     = 3'd3,
        S_EXEC       = 3'd4,
        S_EXC_SAVE   = 3'd5,
        S_EXC_WAIT   = 3'd6
    } state_t;

    localparam logic [2:0] SRC_ALU_RES = 3'b000;
    localparam logic [2:0] SRC_ALU_OUT = 3'b001;
    localparam logic [2:0] SRC_JUMP    = 3'b010;
    localparam logic [2:0] SRC_EPC     = 3'b100;
    localparam logic [2:0] SRC_VEC     = 3'b110;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_COP0  = 6'h10;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_RTE   = 6'h13;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] epc_q, epc_d;
    logic [1:0]  vsel_q, vsel_d;

    logic [2:0]  src_s;
    logic        pc_we_s;
    logic        epc_we_s;
    logic        ir_we_s;
    logic        mem_rd_s;
    logic        iord_s;
    logic [31:0] next_pc_s;

    logic is_jump, is_jr, is_beq, is_bne, is_rte;
    logic unused_mem;

    assign is_jump = (opcode == OP_J) || (opcode == OP_JAL);
    assign is_jr   = (opcode == OP_RTYPE) && (funct == FN_JR);
    assign is_beq  = (opcode == OP_BEQ);
    assign is_bne  = (opcode == OP_BNE);
    assign is_rte  = (opcode == OP_COP0) && (funct == FN_RTE);

    assign unused_mem = ^mem_data[31:8];

    always_comb begin
        state_d  = state_q;
        vsel_d   = vsel_q;
        src_s    = SRC_ALU_RES;
        pc_we_s  = 1'b0;
        epc_we_s = 1'b0;
        ir_we_s  = 1'b0;
        mem_rd_s = 1'b0;
        iord_s   = 1'b0;
        unique case (state_q)
            S_RESET: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_rd_s = 1'b1;
                state_d  = S_FETCH_WAIT;
            end
            S_FETCH_WAIT: begin
                ir_we_s = 1'b1;
                pc_we_s = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (exc_req) begin
                    vsel_d  = exc_code[1] ? 2'd2 : exc_code;
                    state_d = S_EXC_SAVE;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // Exception outranks every transfer and instr_done
                if (exc_req) begin
                    vsel_d  = exc_code[1] ? 2'd2 : exc_code;
                    state_d = S_EXC_SAVE;
                end else if (is_jump) begin
                    src_s   = SRC_JUMP;
                    pc_we_s = 1'b1;
                    state_d = S_FETCH;
                end else if (is_jr) begin
                    pc_we_s = 1'b1;
                    state_d = S_FETCH;
                end else if (is_beq) begin
                    src_s   = SRC_ALU_OUT;
                    pc_we_s = zero;
                    state_d = S_FETCH;
                end else if (is_bne) begin
                    src_s   = SRC_ALU_OUT;
                    pc_we_s = ~zero;
                    state_d = S_FETCH;
                end else if (is_rte) begin
                    src_s   = SRC_EPC;
                    pc_we_s = 1'b1;
                    state_d = S_FETCH;
                end else if (instr_done) begin
                    state_d = S_FETCH;
                end
            end
            S_EXC_SAVE: begin
                epc_we_s = 1'b1;
                mem_rd_s = 1'b1;
                iord_s   = 1'b1;
                state_d  = S_EXC_WAIT;
            end
            S_EXC_WAIT: begin
                src_s   = SRC_VEC;
                pc_we_s = 1'b1;
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_RESET;
            end
        endcase
    end

    always_comb begin
        next_pc_s = alu_result;
        unique case (src_s)
            SRC_ALU_OUT: next_pc_s = alu_out;
            SRC_JUMP:    next_pc_s = {pc_q[31:28], instr_index, 2'b00};
            SRC_EPC:     next_pc_s = epc_q;
            SRC_VEC:     next_pc_s = {24'b0, mem_data[7:0]};
            default:     next_pc_s = alu_result;
        endcase
    end

    always_comb begin
        pc_d  = pc_we_s ? next_pc_s : pc_q;
        epc_d = epc_we_s ? (pc_q - 32'd4) : epc_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RESET;
            pc_q    <= 32'd0;
            epc_q   <= 32'd0;
            vsel_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            vsel_q  <= vsel_d;
        end
    end

    assign pc        = pc_q;
    assign epc       = epc_q;
    assign pc_source = src_s;
    assign pc_write  = pc_we_s;
    assign epc_write = epc_we_s;
    assign ir_write  = ir_we_s;
    assign mem_read  = mem_rd_s;
    assign iord      = iord_s;
    assign vec_addr  = 32'd253 + {30'd0, vsel_q};
    assign state     = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed table, reset corner cases and
// random instruction streams checked against an instruction-level model.
`timescale 1ns/1ps
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [25:0] instr_index;
    logic        zero;
    logic [31:0] alu_result;
    logic [31:0] alu_out;
    logic [31:0] mem_data;
    logic        instr_done;
    logic        exc_req;
    logic [1:0]  exc_code;
    logic [31:0] pc;
    logic [31:0] epc;
    logic [2:0]  pc_source;
    logic        pc_write;
    logic        epc_write;
    logic        ir_write;
    logic        mem_read;
    logic        iord;
    logic [31:0] vec_addr;
    logic [2:0]  state;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .instr_index(instr_index), .zero(zero), .alu_result(alu_result),
        .alu_out(alu_out), .mem_data(mem_data), .instr_done(instr_done),
        .exc_req(exc_req), .exc_code(exc_code), .pc(pc), .epc(epc),
        .pc_source(pc_source), .pc_write(pc_write), .epc_write(epc_write),
        .ir_write(ir_write), .mem_read(mem_read), .iord(iord),
        .vec_addr(vec_addr), .state(state)
    );

    // exc_at: -1 none, 0 in DECODE, 1 in EXEC after ed extra EXEC cycles
    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [25:0] idx;
        logic        zero;
        logic [31:0] aluout;
        logic [31:0] jrt;
        logic [31:0] memd;
        int          dd;
        int          exc_at;
        int          ed;
        logic [1:0]  code;
        logic [31:0] exp_pc;
        logic [31:0] exp_epc;
        int          exp_cyc;
    } vec_t;

    int n_run = 0;
    int n_fail = 0;
    logic [31:0] mpc, mepc;
    vec_t tbl[19];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic [5:0] op, input logic [5:0] fn, input logic [25:0] idx,
        input logic z, input logic [31:0] ao, input logic [31:0] jrt,
        input logic [31:0] memd, input int dd, input int exc_at,
        input int ed, input logic [1:0] code, input logic [31:0] epcv,
        input logic [31:0] eepc, input int ecyc);
        vec_t v;
        v.op = op; v.fn = fn; v.idx = idx; v.zero = z; v.aluout = ao;
        v.jrt = jrt; v.memd = memd; v.dd = dd; v.exc_at = exc_at;
        v.ed = ed; v.code = code; v.exp_pc = epcv; v.exp_epc = eepc;
        v.exp_cyc = ecyc;
        return v;
    endfunction

    // Instruction-level outcome: final pc/epc, cycle count, EXEC strobes
    task automatic model(input vec_t v, input logic [31:0] pc0,
                         input logic [31:0] epc0, output logic [31:0] npc,
                         output logic [31:0] nepc, output int cyc,
                         output logic [2:0] src, output logic pw);
        logic [31:0] p4;
        p4 = pc0 + 32'd4;
        npc = p4; nepc = epc0; src = 3'b000; pw = 1'b0; cyc = 4 + v.dd;
        if (v.exc_at == 0) begin
            nepc = pc0; npc = {24'd0, v.memd[7:0]}; cyc = 5;
        end else if (v.exc_at == 1) begin
            nepc = pc0; npc = {24'd0, v.memd[7:0]}; cyc = 6 + v.ed;
        end else if (v.op == 6'h02 || v.op == 6'h03) begin
            npc = {p4[31:28], v.idx, 2'b00}; src = 3'b010; pw = 1'b1; cyc = 4;
        end else if (v.op == 6'h00 && v.fn == 6'h08) begin
            npc = v.jrt; pw = 1'b1; cyc = 4;
        end else if (v.op == 6'h04) begin
            src = 3'b001; pw = v.zero; cyc = 4;
            if (v.zero) npc = v.aluout;
        end else if (v.op == 6'h05) begin
            src = 3'b001; pw = ~v.zero; cyc = 4;
            if (!v.zero) npc = v.aluout;
        end else if (v.op == 6'h10 && v.fn == 6'h13) begin
            npc = epc0; src = 3'b100; pw = 1'b1; cyc = 4;
        end
    endtask

    // Entered at a negedge with the DUT expected in FETCH
    task automatic run(input vec_t v, input int stop_k);
        logic [31:0] mp, me;
        int mc, exk, ks;
        logic [2:0] src;
        logic pw;
        logic [31:0] vexp;
        model(v, mpc, mepc, mp, me, mc, src, pw);
        exk = (v.exc_at == 0) ? 2 : ((v.exc_at == 1) ? 3 + v.ed : -1);
        ks = (exk >= 0) ? exk + 1 : -1;
        vexp = 32'd253 + ((v.code >= 2'd2) ? 32'd2 : 32'(v.code));
        for (int k = 0; k < v.exp_cyc; k++) begin
            opcode      = (k >= 2) ? v.op : 6'h02;
            funct       = (k >= 2) ? v.fn : 6'h08;
            instr_index = v.idx;
            zero        = (k >= 3) ? v.zero : ~v.zero;
            alu_result  = (k == 1) ? mpc + 32'd4 :
                          ((k >= 3) ? v.jrt : 32'hDEAD_0000);
            alu_out     = v.aluout;
            mem_data    = (ks >= 0 && k == ks + 1) ? v.memd : 32'h5A5A_5A5A;
            exc_req     = (k < 2) || (k == exk) || (ks >= 0 && k >= ks);
            exc_code    = (k == exk) ? v.code : 2'b11;
            instr_done  = (k <= 2) || (k == 3 + v.dd);
            #1;
            if (k == 0) begin
                chk("fetch_state", 32'(state), 32'd1);
                chk("fetch_mem_read", 32'(mem_read), 32'd1);
                chk("fetch_iord", 32'(iord), 32'd0);
            end
            if (k == 1) begin
                chk("fw_ir_write", 32'(ir_write), 32'd1);
                chk("fw_pc_write", 32'(pc_write), 32'd1);
            end
            if (k == 3 && exk != 2 && exk != 3) begin
                chk("exec_pc_source", 32'(pc_source), 32'(src));
                chk("exec_pc_write", 32'(pc_write), 32'(pw));
            end
            if (ks >= 0 && k == ks) begin
                chk("save_state", 32'(state), 32'd5);
                chk("save_epc_write", 32'(epc_write), 32'd1);
                chk("save_iord", 32'(iord), 32'd1);
                chk("save_vec_addr", vec_addr, vexp);
            end
            if (ks >= 0 && k == ks + 1) begin
                chk("wait_pc_source", 32'(pc_source), 32'd6);
                chk("wait_pc_write", 32'(pc_write), 32'd1);
            end
            if (k == stop_k) return;
            @(negedge clk);
        end
        chk("end_state", 32'(state), 32'd1);
        chk("end_pc", pc, v.exp_pc);
        chk("end_epc", epc, v.exp_epc);
        mpc = v.exp_pc;
        mepc = v.exp_epc;
    endtask

    function automatic vec_t rnd_vec();
        vec_t v;
        int kind;
        logic xfer;
        kind = int'($urandom_range(0, 7));
        v = mk(6'h00, 6'h20, 26'($urandom), 1'($urandom), $urandom,
               $urandom, $urandom, int'($urandom_range(0, 3)), -1, 0,
               2'($urandom), 0, 0, 0);
        case (kind)
            1: v.op = 6'h02;
            2: v.op = 6'h03;
            3: v.fn = 6'h08;
            4: v.op = 6'h04;
            5: v.op = 6'h05;
            6: begin v.op = 6'h10; v.fn = 6'h13; end
            7: v.op = 6'h23;
            default: ;
        endcase
        xfer = (kind >= 1 && kind <= 6);
        case ($urandom_range(0, 3))
            0: v.exc_at = 0;
            1: begin
                v.exc_at = 1;
                v.ed = xfer ? 0 : int'($urandom_range(0, v.dd));
            end
            default: ;
        endcase
        return v;
    endfunction

    initial begin
        logic [2:0] s;
        logic p;
        vec_t v;
        reset = 1'b1;
        opcode = '0; funct = '0; instr_index = '0; zero = 1'b0;
        alu_result = '0; alu_out = '0; mem_data = '0;
        instr_done = 1'b0; exc_req = 1'b0; exc_code = '0;

        tbl[0]  = mk(6'h00, 6'h20, 0, 0, 0, 0, 0, 0, -1, 0, 0, 32'h4, 0, 4);
        tbl[1]  = mk(6'h00, 6'h20, 0, 0, 0, 0, 0, 0, -1, 0, 0, 32'h8, 0, 4);
        tbl[2]  = mk(6'h00, 6'h20, 0, 0, 0, 0, 0, 0, -1, 0, 0, 32'hC, 0, 4);
        tbl[3]  = mk(6'h04, 0, 0, 1, 32'h40, 0, 0, 0, -1, 0, 0, 32'h40, 0, 4);
        tbl[4]  = mk(6'h05, 0, 0, 1, 32'h80, 0, 0, 0, -1, 0, 0, 32'h44, 0, 4);
        tbl[5]  = mk(6'h00, 6'h08, 0, 0, 0, 32'h8, 0, 0, -1, 0, 0, 32'h8, 0, 4);
        tbl[6]  = mk(6'h02, 0, 26'h10, 0, 0, 0, 0, 0, -1, 0, 0, 32'h40, 0, 4);
        tbl[7]  = mk(6'h00, 6'h08, 0, 0, 0, 32'h100, 0, 0, -1, 0, 0,
                     32'h100, 0, 4);
        tbl[8]  = mk(6'h00, 6'h08, 0, 0, 0, 32'h20, 0, 0, -1, 0, 0,
                     32'h20, 0, 4);
        tbl[9]  = mk(6'h00, 6'h20, 0, 0, 0, 0, 32'hA0, 0, 1, 0, 2'd1,
                     32'hA0, 32'h20, 6);
        tbl[10] = mk(6'h10, 6'h13, 0, 0, 0, 0, 0, 0, -1, 0, 0,
                     32'h20, 32'h20, 4);
        tbl[11] = mk(6'h3F, 0, 0, 0, 0, 0, 32'h10, 0, 0, 0, 2'd0,
                     32'h10, 32'h20, 5);
        tbl[12] = mk(6'h00, 6'h22, 0, 0, 0, 0, 32'h1FF, 2, 1, 2, 2'd3,
                     32'hFF, 32'h10, 8);
        tbl[13] = mk(6'h00, 6'h08, 0, 0, 0, 32'hF000_0000, 0, 0, -1, 0, 0,
                     32'hF000_0000, 32'h10, 4);
        tbl[14] = mk(6'h02, 0, 26'h3FF_FFFF, 0, 0, 0, 0, 0, -1, 0, 0,
                     32'hFFFF_FFFC, 32'h10, 4);
        tbl[15] = mk(6'h23, 0, 0, 0, 0, 0, 32'h04, 0, 0, 0, 2'd2,
                     32'h4, 32'hFFFF_FFFC, 5);
        tbl[16] = mk(6'h00, 6'h20, 0, 0, 0, 0, 0, 3, -1, 0, 0,
                     32'h8, 32'hFFFF_FFFC, 7);
        tbl[17] = mk(6'h04, 0, 0, 0, 32'h500, 0, 0, 0, -1, 0, 0,
                     32'hC, 32'hFFFF_FFFC, 4);
        tbl[18] = mk(6'h03, 0, 26'h100, 0, 0, 0, 0, 0, -1, 0, 0,
                     32'h400, 32'hFFFF_FFFC, 4);

        repeat (2) @(negedge clk);
        chk("rst_pc", pc, 32'd0);
        chk("rst_epc", epc, 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_strobes", 32'({pc_write, epc_write, ir_write, mem_read}), 0);
        chk("rst_pc_source", 32'(pc_source), 32'd0);
        chk("rst_iord", 32'(iord), 32'd0);
        chk("rst_vec_addr", vec_addr, 32'd253);
        reset = 1'b0;
        #1;
        chk("rel_state", 32'(state), 32'd0);
        @(negedge clk);
        mpc = 32'd0;
        mepc = 32'd0;

        foreach (tbl[i]) run(tbl[i], -1);

        // Reset pulse in EXC_WAIT clears everything within the cycle
        v = mk(6'h00, 6'h20, 0, 0, 0, 0, 32'h77, 0, 1, 0, 2'd1, 0, 0, 0);
        model(v, mpc, mepc, v.exp_pc, v.exp_epc, v.exp_cyc, s, p);
        run(v, 5);
        chk("pre_rst_epc", epc, mpc);
        reset = 1'b1;
        #1;
        chk("arst_pc", pc, 32'd0);
        chk("arst_epc", epc, 32'd0);
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_pc_write", 32'(pc_write), 32'd0);
        @(negedge clk);
        chk("arst_hold_pc", pc, 32'd0);
        chk("arst_hold_epc", epc, 32'd0);
        reset = 1'b0;
        #1;
        chk("arst_rel_pc_write", 32'(pc_write), 32'd0);
        @(negedge clk);
        mpc = 32'd0;
        mepc = 32'd0;

        for (int n = 0; n < 60; n++) begin
            v = rnd_vec();
            model(v, mpc, mepc, v.exp_pc, v.exp_epc, v.exp_cyc, s, p);
            run(v, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
